// File: rtl/locking_rr_arbiter_pkg.sv
// Shared types, width helpers and the rotated-priority pick used by the
// round-robin arbiters.
package locking_rr_arbiter_pkg;

   localparam int unsigned N_IN_DEF      = 4;
   localparam int unsigned DATA_W_DEF    = 64;
   localparam int unsigned MAX_BEATS_DEF = 8;

   // The pick function works on a fixed 16-wide view; callers zero-pad.
   localparam int unsigned MAX_N      = 16;
   localparam int unsigned PICK_IDX_W = 4;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_LOCKED = 1'b1
   } lock_state_e;

   typedef struct packed {
      logic                  any;
      logic [PICK_IDX_W-1:0] idx;
   } pick_t;

   function automatic int unsigned idx_w(input int unsigned n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

   function automatic int unsigned cnt_w(input int unsigned max_beats);
      return $clog2(max_beats + 1);
   endfunction

   // First valid index scanning last+1, last+2, ... modulo n.
   function automatic pick_t rr_pick(input logic [MAX_N-1:0]      valid,
                                     input logic [PICK_IDX_W-1:0] last,
                                     input int unsigned           n);
      pick_t       res;
      int unsigned cand;
      res = '0;
      for (int unsigned k = 1; k <= MAX_N; k++) begin
         cand = (32'(last) + k) % n;
         if (!res.any && (k <= n) && valid[cand[PICK_IDX_W-1:0]]) begin
            res.any = 1'b1;
            res.idx = cand[PICK_IDX_W-1:0];
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/locking_rr_arbiter_rr_priority_pick.sv
// Combinational round-robin pick: first valid requester after last_grant.
module rr_priority_pick
   import locking_rr_arbiter_pkg::*;
#(
   parameter int unsigned N_IN = N_IN_DEF
) (
   input  logic [N_IN-1:0]        valid_i,
   input  logic [idx_w(N_IN)-1:0] last_grant_i,
   output logic [idx_w(N_IN)-1:0] chosen_o,
   output logic                   any_valid_o
);

   localparam int unsigned IDX_W = idx_w(N_IN);

   pick_t pick;

   always_comb begin
      pick        = rr_pick(MAX_N'(valid_i), PICK_IDX_W'(last_grant_i), N_IN);
      chosen_o    = IDX_W'(pick.idx);
      any_valid_o = pick.any;
   end

endmodule

// File: rtl/locking_rr_arbiter.sv
// Round-robin valid/ready arbiter that locks the shared output to one
// requester for the duration of a multi-beat burst, with a beat watchdog.
module locking_rr_arbiter
   import locking_rr_arbiter_pkg::*;
#(
   parameter int unsigned N_IN      = N_IN_DEF,
   parameter int unsigned DATA_W    = DATA_W_DEF,
   parameter int unsigned MAX_BEATS = MAX_BEATS_DEF
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic [N_IN-1:0]          io_in_valid,
   output logic [N_IN-1:0]          io_in_ready,
   input  logic [N_IN*DATA_W-1:0]   io_in_bits,
   input  logic [N_IN-1:0]          io_in_last,
   output logic                     io_out_valid,
   input  logic                     io_out_ready,
   output logic [DATA_W-1:0]        io_out_bits,
   output logic                     io_out_last,
   output logic [idx_w(N_IN)-1:0]   io_chosen,
   output logic                     io_locked,
   output logic                     io_burst_err
);

   localparam int unsigned IDX_W = idx_w(N_IN);
   localparam int unsigned CNT_W = cnt_w(MAX_BEATS);

   lock_state_e       state_q, state_d;
   logic [IDX_W-1:0]  last_grant_q, last_grant_d;
   logic [IDX_W-1:0]  lock_idx_q, lock_idx_d;
   logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;
   logic              err_q, err_d;

   logic [IDX_W-1:0]  rr_idx;
   logic              rr_any;
   logic [IDX_W-1:0]  chosen_c;
   logic              fire_c;
   logic              last_c;
   logic              watchdog_c;

   rr_priority_pick #(
      .N_IN (N_IN)
   ) u_pick (
      .valid_i      (io_in_valid),
      .last_grant_i (last_grant_q),
      .chosen_o     (rr_idx),
      .any_valid_o  (rr_any)
   );

   // State register; async reset drops any in-flight burst.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         last_grant_q <= IDX_W'(N_IN - 1);
         lock_idx_q   <= '0;
         beat_cnt_q   <= '0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         lock_idx_q   <= lock_idx_d;
         beat_cnt_q   <= beat_cnt_d;
         err_q        <= err_d;
      end
   end

   // Next-state: lock on a non-last beat, release on last or watchdog.
   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      lock_idx_d   = lock_idx_q;
      beat_cnt_d   = beat_cnt_q;
      err_d        = 1'b0;
      watchdog_c   = (32'(beat_cnt_q) + 32'd1) == MAX_BEATS;
      case (state_q)
         ST_IDLE: begin
            if (fire_c) begin
               if (last_c) begin
                  last_grant_d = chosen_c;
               end else begin
                  state_d    = ST_LOCKED;
                  lock_idx_d = chosen_c;
                  beat_cnt_d = CNT_W'(1);
               end
            end
         end
         ST_LOCKED: begin
            if (fire_c) begin
               if (last_c || watchdog_c) begin
                  state_d      = ST_IDLE;
                  last_grant_d = lock_idx_q;
                  beat_cnt_d   = '0;
                  err_d        = !last_c;
               end else begin
                  beat_cnt_d = beat_cnt_q + CNT_W'(1);
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Outputs: grant mux is purely a function of state and requester inputs.
   always_comb begin
      chosen_c = (state_q == ST_LOCKED) ? lock_idx_q : (rr_any ? rr_idx : '0);
      io_chosen    = chosen_c;
      io_out_valid = io_in_valid[chosen_c];
      io_out_bits  = io_in_bits[chosen_c*DATA_W +: DATA_W];
      io_out_last  = io_in_last[chosen_c];
      last_c       = io_in_last[chosen_c];
      fire_c       = io_in_valid[chosen_c] && io_out_ready;
      io_in_ready  = '0;
      io_in_ready[chosen_c] = io_out_ready;
      io_locked    = (state_q == ST_LOCKED);
      io_burst_err = err_q;
   end

endmodule

// File: tb/tb_locking_rr_arbiter.sv
// Scoreboard bench for locking_rr_arbiter: stimulus queues expected grants,
// a negedge monitor checks every accepted beat.
module tb_locking_rr_arbiter;

   localparam int unsigned N  = 4;
   localparam int unsigned DW = 64;

   logic            clock = 1'b0;
   logic            reset = 1'b1;
   logic [N-1:0]    io_in_valid = '0;
   logic [N-1:0]    io_in_ready;
   logic [N*DW-1:0] io_in_bits = '0;
   logic [N-1:0]    io_in_last = '0;
   logic            io_out_valid;
   logic            io_out_ready = 1'b0;
   logic [DW-1:0]   io_out_bits;
   logic            io_out_last;
   logic [1:0]      io_chosen;
   logic            io_locked;
   logic            io_burst_err;

   locking_rr_arbiter #(.N_IN(4), .DATA_W(64), .MAX_BEATS(8)) dut (
      .clock        (clock),
      .reset        (reset),
      .io_in_valid  (io_in_valid),
      .io_in_ready  (io_in_ready),
      .io_in_bits   (io_in_bits),
      .io_in_last   (io_in_last),
      .io_out_valid (io_out_valid),
      .io_out_ready (io_out_ready),
      .io_out_bits  (io_out_bits),
      .io_out_last  (io_out_last),
      .io_chosen    (io_chosen),
      .io_locked    (io_locked),
      .io_burst_err (io_burst_err)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [1:0]  idx;
      logic        lk;
      logic [63:0] data;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;
   int   wd_idx [11];
   int   wd_lk  [11];

   function automatic logic [63:0] pay(input int i, input int b);
      return {32'(i), 32'hC0DE_0000 + 32'(b)};
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic set_bits(input int b);
      for (int i = 0; i < 4; i++) io_in_bits[i*64 +: 64] = pay(i, b);
   endtask

   task automatic push(input int idx, input int lk, input int b);
      exp_t e;
      e.idx  = 2'(idx);
      e.lk   = 1'(lk);
      e.data = pay(idx, b);
      q.push_back(e);
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   // Monitor: every accepted beat must match the head of the scoreboard.
   always @(negedge clock) begin
      if (!reset && io_out_valid && io_out_ready) begin
         if (q.size() == 0) begin
            chk("unexpected_fire", 64'(io_chosen), 64'hFFFF);
         end else begin
            exp_t e;
            logic [3:0] oh;
            e  = q.pop_front();
            oh = 4'b0001 << e.idx;
            chk("chosen", 64'(io_chosen), 64'(e.idx));
            chk("locked", 64'(io_locked), 64'(e.lk));
            chk("bits", io_out_bits, e.data);
            chk("in_ready", 64'(io_in_ready), 64'(oh));
         end
      end
   end

   initial begin
      wd_idx = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0};
      wd_lk  = '{0, 1, 1, 1, 1, 1, 1, 1, 0, 0, 1};
      set_bits(0);
      #12;
      reset = 1'b0;
      step();

      // Reset state
      chk("rst_locked", 64'(io_locked), 64'd0);
      chk("rst_err", 64'(io_burst_err), 64'd0);
      chk("rst_out_valid", 64'(io_out_valid), 64'd0);
      chk("rst_chosen", 64'(io_chosen), 64'd0);
      chk("rst_in_ready", 64'(io_in_ready), 64'd0);

      // Plain round robin over all four single-beat requesters
      io_in_valid  = 4'b1111;
      io_in_last   = 4'b1111;
      io_out_ready = 1'b1;
      for (int k = 0; k < 8; k++) push(k % 4, 0, 0);
      repeat (8) step();
      io_in_valid = 4'b0000;

      // Move last_grant to 1, then a 4-beat burst from requester 2
      io_in_valid = 4'b0010;
      push(1, 0, 0);
      step();
      io_in_valid = 4'b1111;
      io_in_last  = 4'b1011;
      push(2, 0, 0);
      step();
      set_bits(1); push(2, 1, 1);
      step();
      set_bits(2); push(2, 1, 2);
      step();
      set_bits(3); io_in_last = 4'b1111; push(2, 1, 3);
      step();
      push(3, 0, 3);
      step();
      io_in_valid = 4'b0000;

      // Lock on requester 1, then stall the downstream for 5 cycles
      set_bits(0);
      io_in_valid = 4'b0010;
      io_in_last  = 4'b0000;
      push(1, 0, 0);
      step();
      io_out_ready = 1'b0;
      io_in_valid  = 4'b1011;
      for (int k = 0; k < 5; k++) begin
         @(negedge clock);
         chk("stall_in_ready", 64'(io_in_ready), 64'd0);
         chk("stall_locked", 64'(io_locked), 64'd1);
         chk("stall_chosen", 64'(io_chosen), 64'd1);
      end
      step();
      io_out_ready = 1'b1;
      io_in_last   = 4'b0010;
      set_bits(1);
      push(1, 1, 1);
      step();
      io_in_valid = 4'b0000;

      // Watchdog: requester 0 streams without last, requester 1 single beats
      io_in_valid = 4'b0011;
      io_in_last  = 4'b0010;
      for (int c = 0; c < 11; c++) begin
         set_bits(c);
         push(wd_idx[c], wd_lk[c], c);
         @(negedge clock);
         chk("burst_err", 64'(io_burst_err), (c == 8) ? 64'd1 : 64'd0);
         step();
      end
      io_in_valid = 4'b0000;
      @(negedge clock);
      chk("burst_err_clear", 64'(io_burst_err), 64'd0);
      step();

      // Close requester 0's burst, then lock on 3 with two beats accepted
      io_in_valid = 4'b0001;
      io_in_last  = 4'b0001;
      set_bits(11); push(0, 1, 11);
      step();
      io_in_valid = 4'b1000;
      io_in_last  = 4'b0000;
      set_bits(12); push(3, 0, 12);
      step();
      set_bits(13); push(3, 1, 13);
      step();
      io_in_valid  = 4'b1001;
      io_out_ready = 1'b0;
      #1;
      chk("pre_rst_locked", 64'(io_locked), 64'd1);
      chk("pre_rst_chosen", 64'(io_chosen), 64'd3);
      #1;
      reset = 1'b1;
      #1;
      chk("async_rst_locked", 64'(io_locked), 64'd0);
      chk("async_rst_chosen", 64'(io_chosen), 64'd0);
      chk("async_rst_err", 64'(io_burst_err), 64'd0);
      @(negedge clock);
      reset = 1'b0;
      step();
      io_out_ready = 1'b1;
      io_in_last   = 4'b1001;
      push(0, 0, 13);
      step();
      push(3, 0, 13);
      step();
      io_in_valid = 4'b0000;

      // Lone requester 3 keeps winning until requester 0 shows up
      io_in_valid = 4'b1000;
      io_in_last  = 4'b1001;
      for (int c = 20; c < 23; c++) begin
         set_bits(c); push(3, 0, c);
         step();
      end
      io_in_valid = 4'b0001;
      set_bits(23); push(0, 0, 23);
      step();
      io_in_valid = 4'b0000;

      // Drain: all queued grants must have been observed
      for (int k = 0; k < 20 && q.size() != 0; k++) @(negedge clock);
      chk("scoreboard_drained", 64'(q.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
